// File: rtl/vga_pkg.sv
// Shared VGA display constants: default 640x480@60 timing, colour select codes and cell encodings.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned BOARD_X0_DEF     = 80;
  localparam int unsigned CELL_SIZE_DEF    = 160;
  localparam int unsigned LINE_W_DEF       = 4;
  localparam int unsigned BLINK_FRAMES_DEF = 30;
  localparam int unsigned SELECT_SIZE_DEF  = 3;

  localparam logic [2:0] SEL_BLACK = 3'b000;
  localparam logic [2:0] SEL_WHITE = 3'b111;
  localparam logic [2:0] SEL_RED   = 3'b100;
  localparam logic [2:0] SEL_GREEN = 3'b010;
  localparam logic [2:0] SEL_BLUE  = 3'b001;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_X     = 2'b01,
    CELL_O     = 2'b10,
    CELL_RSVD  = 2'b11
  } cell_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running raster counters with unregistered sync / active-area decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int unsigned VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_line_end,
  output logic          o_frame_end,
  output logic          o_frame_start,
  output logic          o_hsync_n,
  output logic          o_vsync_n,
  output logic          o_active
);

  localparam int unsigned HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS0 = H_ACTIVE + H_FP;
  localparam int unsigned HS1 = HS0 + H_SYNC;
  localparam int unsigned VS0 = V_ACTIVE + V_FP;
  localparam int unsigned VS1 = VS0 + V_SYNC;

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_line_end;
  logic          w_frame_end;

  assign w_line_end  = (r_h_cnt == HW'(HT - 1));
  assign w_frame_end = w_line_end && (r_v_cnt == VW'(VT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_line_end) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_frame_end ? '0 : r_v_cnt + VW'(1);
    end else begin
      r_h_cnt <= r_h_cnt + HW'(1);
    end
  end

  assign o_h_cnt       = r_h_cnt;
  assign o_v_cnt       = r_v_cnt;
  assign o_line_end    = w_line_end;
  assign o_frame_end   = w_frame_end;
  assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign o_hsync_n     = !((r_h_cnt >= HW'(HS0)) && (r_h_cnt < HW'(HS1)));
  assign o_vsync_n     = !((r_v_cnt >= VW'(VS0)) && (r_v_cnt < VW'(VS1)));
  assign o_active      = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));

endmodule

// File: rtl/vga_board_renderer.sv
// TicTacToe board renderer: cell tracking, frame-latched board/cursor, cursor blink and
// per-pixel colour priority, with all outputs registered one cycle behind the raster counters.
module vga_board_renderer
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned H_FP         = H_FP_DEF,
  parameter int unsigned H_SYNC       = H_SYNC_DEF,
  parameter int unsigned H_BP         = H_BP_DEF,
  parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
  parameter int unsigned V_FP         = V_FP_DEF,
  parameter int unsigned V_SYNC       = V_SYNC_DEF,
  parameter int unsigned V_BP         = V_BP_DEF,
  parameter int unsigned BOARD_X0     = BOARD_X0_DEF,
  parameter int unsigned CELL_SIZE    = CELL_SIZE_DEF,
  parameter int unsigned LINE_W       = LINE_W_DEF,
  parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEF,
  parameter int unsigned SELECT_SIZE  = SELECT_SIZE_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [17:0]            board_i,
  input  logic [3:0]             cursor_i,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   inActiveArea_o,
  output logic [SELECT_SIZE-1:0] select_o,
  output logic                   frame_start_o
);

  localparam int unsigned HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int unsigned VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int unsigned CW       = $clog2(CELL_SIZE);
  localparam int unsigned BW       = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned BOARD_X1 = BOARD_X0 + 3 * CELL_SIZE;

  logic [HW-1:0] w_h_cnt;
  logic [VW-1:0] w_v_cnt;
  logic          w_line_end, w_frame_end, w_frame_start;
  logic          w_hsync_n, w_vsync_n, w_active;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .i_clk        (clk_i),
    .i_rst_n      (rst_ni),
    .o_h_cnt      (w_h_cnt),
    .o_v_cnt      (w_v_cnt),
    .o_line_end   (w_line_end),
    .o_frame_end  (w_frame_end),
    .o_frame_start(w_frame_start),
    .o_hsync_n    (w_hsync_n),
    .o_vsync_n    (w_vsync_n),
    .o_active     (w_active)
  );

  logic [CW-1:0] r_cx, r_cy;
  logic [1:0]    r_col, r_row;
  logic [17:0]   r_board;
  logic [3:0]    r_cursor;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_on;

  // Loaded one cycle early so cx/col read 0 exactly when h_cnt reaches BOARD_X0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cx  <= '0;
      r_col <= '0;
    end else if (w_h_cnt == HW'(BOARD_X0 - 1)) begin
      r_cx  <= '0;
      r_col <= '0;
    end else if (r_cx == CW'(CELL_SIZE - 1)) begin
      r_cx  <= '0;
      r_col <= r_col + 2'd1;
    end else begin
      r_cx <= r_cx + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cy  <= '0;
      r_row <= '0;
    end else if (w_line_end) begin
      if (w_frame_end) begin
        r_cy  <= '0;
        r_row <= '0;
      end else if (r_cy == CW'(CELL_SIZE - 1)) begin
        r_cy  <= '0;
        r_row <= r_row + 2'd1;
      end else begin
        r_cy <= r_cy + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_board     <= '0;
      r_cursor    <= '1;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_frame_start) begin
      r_board  <= board_i;
      r_cursor <= cursor_i;
      if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_on  <= !r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  logic       w_in_board, w_grid, w_edge, w_cursor_hit;
  logic [3:0] w_cell;
  logic [1:0] w_mark_bits;
  logic [2:0] w_sel;

  assign w_in_board   = (w_h_cnt >= HW'(BOARD_X0)) && (w_h_cnt < HW'(BOARD_X1)) &&
                        (w_v_cnt < VW'(3 * CELL_SIZE));
  assign w_cell       = 4'({r_row, 1'b0}) + 4'(r_row) + 4'(r_col);
  assign w_mark_bits  = 2'(r_board >> {w_cell, 1'b0});
  assign w_grid       = ((r_cx < CW'(LINE_W)) && (r_col != 2'd0)) ||
                        ((r_cy < CW'(LINE_W)) && (r_row != 2'd0));
  // Grid pixels are resolved first, so any edge band left here is cursor border.
  assign w_edge       = (r_cx < CW'(LINE_W)) || (r_cx >= CW'(CELL_SIZE - LINE_W)) ||
                        (r_cy < CW'(LINE_W)) || (r_cy >= CW'(CELL_SIZE - LINE_W));
  assign w_cursor_hit = r_blink_on && (r_cursor < 4'd9) && (r_cursor == w_cell);

  always_comb begin
    w_sel = SEL_BLACK;
    if (w_active && w_in_board) begin
      if (w_grid) begin
        w_sel = SEL_WHITE;
      end else if (w_cursor_hit && w_edge) begin
        w_sel = SEL_GREEN;
      end else begin
        case (cell_t'(w_mark_bits))
          CELL_X:  w_sel = SEL_RED;
          CELL_O:  w_sel = SEL_BLUE;
          default: w_sel = SEL_BLACK;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hsync_o        <= 1'b1;
      vsync_o        <= 1'b1;
      inActiveArea_o <= 1'b0;
      select_o       <= '0;
      frame_start_o  <= 1'b0;
    end else begin
      hsync_o        <= w_hsync_n;
      vsync_o        <= w_vsync_n;
      inActiveArea_o <= w_active;
      select_o       <= SELECT_SIZE'(w_sel);
      frame_start_o  <= w_frame_start;
    end
  end

endmodule

// File: tb/tb_vga_board_renderer.sv
// Directed bench for vga_board_renderer on a scaled-down raster (74x46 frame, 12-pixel cells).
module tb_vga_board_renderer;

  localparam int HA = 60, HF = 4, HS = 6, HB = 4;
  localparam int VA = 40, VF = 2, VS = 2, VB = 2;
  localparam int X0 = 8, CS = 12, LW = 2, BF = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  localparam logic [2:0] K = 3'b000, W = 3'b111, R = 3'b100, G = 3'b010, B = 3'b001;
  localparam logic [17:0] BOARD_XO = 18'h20100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] board = '0;
  logic [3:0]  cursor = 4'hF;
  logic        hsync, vsync, active, fs;
  logic [2:0]  sel;

  int cyc;
  int n_vec = 0;
  int n_err = 0;

  vga_board_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BOARD_X0(X0), .CELL_SIZE(CS), .LINE_W(LW), .BLINK_FRAMES(BF),
    .SELECT_SIZE(3)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .board_i       (board),
    .cursor_i      (cursor),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .inActiveArea_o(active),
    .select_o      (sel),
    .frame_start_o (fs)
  );

  always #20 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    string       name;
    int          f, x, y;
    logic [6:0]  exp;
    bit          upd;
    logic [17:0] bd;
    logic [3:0]  cur;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input int f, input int x, input int y,
                     input logic [2:0] s, input logic a, input logic h, input logic v,
                     input logic p, input bit u = 0, input logic [17:0] b = '0,
                     input logic [3:0] c = '0);
    vecs.push_back('{name: nm, f: f, x: x, y: y, exp: {s, a, h, v, p}, upd: u, bd: b, cur: c});
  endtask

  task automatic addp(input string nm, input int f, input int x, input int y,
                      input logic [2:0] s, input bit u = 0, input logic [17:0] b = '0,
                      input logic [3:0] c = '0);
    add(nm, f, x, y, s, 1'b1, 1'b1, 1'b1, 1'b0, u, b, c);
  endtask

  task automatic check7(input string nm, input logic [6:0] exp);
    logic [6:0] got;
    got = {sel, active, hsync, vsync, fs};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got sel=%b act=%b hs=%b vs=%b fs=%b, want sel=%b act=%b hs=%b vs=%b fs=%b",
               nm, got[6:4], got[3], got[2], got[1], got[0],
               exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  // Outputs seen at the negedge after posedge k belong to raster index k-1.
  task automatic wait_idx(input int idx, output bit ok);
    ok = 0;
    for (int n = 0; n < 40000; n++) begin
      @(negedge clk);
      if (cyc == idx + 1) begin
        ok = 1;
        break;
      end
      if (cyc > idx + 1) break;
    end
  endtask

  initial begin
    bit ok;
    int n_fs, n_hs, n_vs, n_act, first_fs, first_hs, first_vs;

    add ("f1_origin",    1,  0,  0, K, 1, 1, 1, 1);
    addp("f1_x0_nocur",  1,  8,  0, K);
    addp("f1_grid_v",    1, 21,  3, W);
    addp("f1_cell2",     1, 40,  3, K);
    addp("f1_outside",   1, 50,  3, K);
    add ("f1_hs_pre",    1, 63,  3, K, 0, 1, 1, 0);
    add ("f1_hs_first",  1, 64,  3, K, 0, 0, 1, 0);
    add ("f1_hs_last",   1, 69,  3, K, 0, 0, 1, 0);
    add ("f1_hs_post",   1, 70,  3, K, 0, 1, 1, 0);
    addp("f1_grid_h",    1, 10, 13, W);
    addp("f1_midframe",  1,  0, 16, K, 1, BOARD_XO, 4'd0);
    addp("f1_old_x",     1, 26, 18, K);
    addp("f1_old_o",     1, 38, 30, K);
    add ("f1_vs_pre",    1,  5, 41, K, 0, 1, 1, 0);
    add ("f1_vs_first",  1,  5, 42, K, 0, 1, 0, 0);
    add ("f1_vs_last",   1,  5, 43, K, 0, 1, 0, 0);
    add ("f1_vs_post",   1,  5, 44, K, 0, 1, 1, 0);
    addp("f2_cur_tl",    2,  9,  1, G);
    addp("f2_cur_right", 2, 18,  5, G);
    addp("f2_cur_inner", 2, 14,  6, K);
    addp("f2_cross",     2, 21, 13, W);
    addp("f2_x",         2, 26, 18, R);
    addp("f2_o",         2, 38, 30, B);
    add ("f3_origin",    3,  0,  0, K, 1, 1, 1, 1);
    addp("f3_blink_off", 3,  9,  1, K);
    addp("f6_blink_on",  6,  9,  1, G, 1, BOARD_XO, 4'd4);
    addp("f7_grid_pri",  7, 21, 18, W);
    addp("f7_x_center",  7, 26, 18, R);
    addp("f7_cur_right", 7, 30, 18, G);
    addp("f7_cur_bot",   7, 26, 23, G, 1, BOARD_XO, 4'd9);
    addp("f8_cell0",     8,  9,  1, K);
    addp("f8_cur9_off",  8, 30, 18, R);

    repeat (3) @(negedge clk);
    check7("reset_state", {K, 1'b0, 1'b1, 1'b1, 1'b0});
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      wait_idx((vecs[i].f - 1) * FRAME + vecs[i].y * HT + vecs[i].x, ok);
      if (!ok) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: pixel never reached (cyc=%0d)", vecs[i].name, cyc);
      end else begin
        check7(vecs[i].name, vecs[i].exp);
      end
      if (vecs[i].upd) begin
        board  = vecs[i].bd;
        cursor = vecs[i].cur;
      end
    end

    // Mid-frame asynchronous reset, then one full frame of timing after release.
    wait_idx(8 * FRAME + 10 * HT + 30, ok);
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL t6_reach: pixel never reached (cyc=%0d)", cyc);
    end
    rst_n = 1'b0;
    #1;
    check7("t6_async_reset", {K, 1'b0, 1'b1, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    check7("t6_reset_held", {K, 1'b0, 1'b1, 1'b1, 1'b0});
    rst_n = 1'b1;

    n_fs = 0; n_hs = 0; n_vs = 0; n_act = 0;
    first_fs = -1; first_hs = -1; first_vs = -1;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (fs) begin
        n_fs++;
        if (first_fs < 0) first_fs = k;
      end
      if (!hsync) begin
        n_hs++;
        if (first_hs < 0) first_hs = k;
      end
      if (!vsync) begin
        n_vs++;
        if (first_vs < 0) first_vs = k;
      end
      if (active) n_act++;
    end
    check_int("t1_first_fs",  first_fs, 0);
    check_int("t1_fs_count",  n_fs, 1);
    check_int("t1_hs_start",  first_hs, HA + HF);
    check_int("t1_hs_low",    n_hs, HS * VT);
    check_int("t1_vs_start",  first_vs, (VA + VF) * HT);
    check_int("t1_vs_low",    n_vs, VS * HT);
    check_int("t1_active",    n_act, HA * VA);
    @(negedge clk);
    check_int("t1_fs_period", int'(fs), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
